// File: rtl/sockit_spi_arb.sv
// Transfer-boundary arbiter sharing the serializer stream path
// between the XIP requester and the REG+DMA requester.
module sockit_spi_arb #(
  parameter int CW  = 32,
  parameter int DW  = 32,
  parameter int LBI = 31,
  parameter int RBI = 30,
  parameter int OCW = 4,
  parameter int PRI = 0
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  input  logic          xip_en,
  input  logic          scw_xip_vld,
  output logic          scw_xip_rdy,
  input  logic [CW-1:0] scw_xip_dat,
  input  logic          scw_reg_vld,
  output logic          scw_reg_rdy,
  input  logic [CW-1:0] scw_reg_dat,
  output logic          scw_cdx_vld,
  input  logic          scw_cdx_rdy,
  output logic [CW-1:0] scw_cdx_dat,
  input  logic          sdw_xip_vld,
  output logic          sdw_xip_rdy,
  input  logic [DW-1:0] sdw_xip_dat,
  input  logic          sdw_dma_vld,
  output logic          sdw_dma_rdy,
  input  logic [DW-1:0] sdw_dma_dat,
  output logic          sdw_cdx_vld,
  input  logic          sdw_cdx_rdy,
  output logic [DW-1:0] sdw_cdx_dat,
  input  logic          sdr_cdx_vld,
  output logic          sdr_cdx_rdy,
  input  logic [DW-1:0] sdr_cdx_dat,
  output logic          sdr_xip_vld,
  input  logic          sdr_xip_rdy,
  output logic [DW-1:0] sdr_xip_dat,
  output logic          sdr_dma_vld,
  input  logic          sdr_dma_rdy,
  output logic [DW-1:0] sdr_dma_dat,
  output logic          sel,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } st_e;

  localparam logic [OCW-1:0] ONE = {{(OCW-1){1'b0}}, 1'b1};

  st_e            st_q, st_d;
  logic           sel_q, sel_d;
  logic           lst_q, lst_d;
  logic [OCW-1:0] cnt_q, cnt_d;

  logic          xip_req;
  logic          reg_req;
  logic          win;
  logic          own_vld;
  logic [CW-1:0] own_dat;
  logic          stall;
  logic          acc;
  logic          inc;
  logic          rd_act;
  logic          rd_rdy;
  logic          rd_hs;

  assign xip_req = scw_xip_vld & xip_en;
  assign reg_req = scw_reg_vld;

  assign own_vld = sel_q ? scw_reg_vld : scw_xip_vld;
  assign own_dat = sel_q ? scw_reg_dat : scw_xip_dat;

  // a read-producing beat must wait while the counter is saturated
  assign stall = own_dat[RBI] & (&cnt_q);
  assign acc   = (st_q == OWN) & own_vld & ~stall & scw_cdx_rdy;
  assign inc   = acc & own_dat[RBI];

  assign rd_act = (st_q != IDLE);
  assign rd_rdy = sel_q ? sdr_dma_rdy : sdr_xip_rdy;
  assign rd_hs  = rd_act & sdr_cdx_vld & rd_rdy;

  // winner on a tie: XIP under fixed priority, else the one not served last
  always_comb begin
    win = ~xip_req;
    if (xip_req && reg_req) begin
      win = (PRI != 0) ? 1'b0 : ~lst_q;
    end
  end

  // outstanding reads: saturating up/down, simultaneous events cancel
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !rd_hs) begin
      cnt_d = cnt_q + ONE;
    end else if (!inc && rd_hs && cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // state, owner, last-served and counter registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      st_q  <= IDLE;
      sel_q <= 1'b0;
      lst_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      sel_q <= sel_d;
      lst_q <= lst_d;
      cnt_q <= cnt_d;
    end
  end

  // next state: grant in IDLE, release after last beat and read drain
  always_comb begin
    st_d  = st_q;
    sel_d = sel_q;
    lst_d = lst_q;
    unique case (st_q)
      IDLE: begin
        if (xip_req || reg_req) begin
          st_d  = OWN;
          sel_d = win;
          lst_d = win;
        end
      end
      OWN: begin
        if (acc && own_dat[LBI]) begin
          st_d = (cnt_d == '0) ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_d == '0) begin
          st_d = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // outputs: stream routing by owner; write words still flush in DRAIN
  always_comb begin
    scw_xip_rdy = 1'b0;
    scw_reg_rdy = 1'b0;
    scw_cdx_vld = 1'b0;
    sdw_xip_rdy = 1'b0;
    sdw_dma_rdy = 1'b0;
    sdw_cdx_vld = 1'b0;
    sdr_cdx_rdy = 1'b0;
    sdr_xip_vld = 1'b0;
    sdr_dma_vld = 1'b0;
    scw_cdx_dat = own_dat;
    sdw_cdx_dat = sel_q ? sdw_dma_dat : sdw_xip_dat;
    sdr_xip_dat = sdr_cdx_dat;
    sdr_dma_dat = sdr_cdx_dat;
    sel         = sel_q;
    busy        = (st_q != IDLE);
    if (st_q == OWN) begin
      scw_cdx_vld = own_vld & ~stall;
      scw_xip_rdy = ~sel_q & scw_cdx_rdy & ~stall;
      scw_reg_rdy = sel_q & scw_cdx_rdy & ~stall;
    end
    if (rd_act) begin
      sdw_cdx_vld = sel_q ? sdw_dma_vld : sdw_xip_vld;
      sdw_xip_rdy = ~sel_q & sdw_cdx_rdy;
      sdw_dma_rdy = sel_q & sdw_cdx_rdy;
      sdr_cdx_rdy = rd_rdy;
      sdr_xip_vld = ~sel_q & sdr_cdx_vld;
      sdr_dma_vld = sel_q & sdr_cdx_vld;
    end
  end

endmodule
